// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix multiplier datapath and its UART loader.
package matrix_pkg;

   localparam int unsigned SIZE       = 4;
   localparam int unsigned DATA_WIDTH = 18;
   localparam int unsigned ADDR_WIDTH = 11;

   // SRAM layout: A, B, then the product C, each SIZE*SIZE words, column-major.
   localparam int unsigned A_BASE = 0;
   localparam int unsigned B_BASE = SIZE * SIZE;
   localparam int unsigned C_BASE = 2 * SIZE * SIZE;

   localparam logic [7:0] ASCII_NUL      = 8'h00;
   localparam logic [7:0] ASCII_TAB      = 8'h09;
   localparam logic [7:0] ASCII_LF       = 8'h0A;
   localparam logic [7:0] ASCII_CR       = 8'h0D;
   localparam logic [7:0] ASCII_SPACE    = 8'h20;
   localparam logic [7:0] ASCII_COMMA    = 8'h2C;
   localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
   localparam logic [7:0] ASCII_RBRACKET = 8'h5D;
   localparam logic [7:0] ASCII_0        = 8'h30;
   localparam logic [7:0] ASCII_9        = 8'h39;
   localparam logic [7:0] ASCII_UA       = 8'h41;
   localparam logic [7:0] ASCII_UF       = 8'h46;
   localparam logic [7:0] ASCII_LA       = 8'h61;
   localparam logic [7:0] ASCII_LF_CHAR  = 8'h66;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE,
      S_ERR
   } loader_state_e;

   // Classification of one received character.
   typedef struct packed {
      logic       is_digit;
      logic       is_sep;
      logic [3:0] nibble;
   } hex_char_t;

endpackage

// File: rtl/matrix_uart_loader_hex_char_decode.sv
// Combinational ASCII classifier: hex digit (with its value), separator, or neither.
module hex_char_decode
   import matrix_pkg::*;
(
   input  logic [7:0] rx_byte_i,
   output hex_char_t  dec_c
);

   // Classify the byte and extract the nibble for hex digits.
   always_comb begin
      dec_c = '0;
      if (rx_byte_i >= ASCII_0 && rx_byte_i <= ASCII_9) begin
         dec_c.is_digit = 1'b1;
         dec_c.nibble   = 4'(rx_byte_i - ASCII_0);
      end else if (rx_byte_i >= ASCII_UA && rx_byte_i <= ASCII_UF) begin
         dec_c.is_digit = 1'b1;
         dec_c.nibble   = 4'(rx_byte_i - ASCII_UA + 8'd10);
      end else if (rx_byte_i >= ASCII_LA && rx_byte_i <= ASCII_LF_CHAR) begin
         dec_c.is_digit = 1'b1;
         dec_c.nibble   = 4'(rx_byte_i - ASCII_LA + 8'd10);
      end else begin
         case (rx_byte_i)
            ASCII_SPACE, ASCII_TAB, ASCII_COMMA, ASCII_CR,
            ASCII_LF, ASCII_LBRACKET, ASCII_RBRACKET: dec_c.is_sep = 1'b1;
            default: dec_c.is_sep = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/matrix_uart_loader.sv
// UART hex-text loader: parses separated hex numbers and writes them column-major
// into the shared SRAM (A at base 0, B at SIZE*SIZE).
// Optional build macro: LOADER_ECHO_EN enables echoing of accepted bytes.
module matrix_uart_loader
   import matrix_pkg::*;
#(
   parameter  int unsigned SIZE       = matrix_pkg::SIZE,
   parameter  int unsigned NUM_MATS   = 2,
   parameter  int unsigned DATA_WIDTH = matrix_pkg::DATA_WIDTH,
   parameter  int unsigned ADDR_WIDTH = matrix_pkg::ADDR_WIDTH,
   parameter  int unsigned MAX_DIGITS = 5,
   localparam int unsigned CW         = $clog2(SIZE * SIZE * NUM_MATS) + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [CW-1:0]         elem_count,
   output logic                  echo_valid,
   output logic [7:0]            echo_byte,
   input  logic                  tx_busy
);

   localparam int unsigned MAT_ELEMS = SIZE * SIZE;
   localparam int unsigned TOTAL     = MAT_ELEMS * NUM_MATS;
   localparam int unsigned NDW       = $clog2(MAX_DIGITS + 1);

   loader_state_e         state_q, state_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [NDW-1:0]        ndig_q, ndig_d;
   logic [CW-1:0]         elem_count_q, elem_count_d;
   logic                  sram_we_q, sram_we_d;
   logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_WIDTH-1:0] sram_data_q, sram_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   hex_char_t             dec;

   hex_char_decode u_decode (
      .rx_byte_i (rx_byte),
      .dec_c     (dec)
   );

   // Text arrives row-major; storage is column-major within each matrix.
   function automatic logic [ADDR_WIDTH-1:0] col_major_addr(input logic [CW-1:0] e);
      int unsigned ei, mat, row, col;
      ei  = 32'(e);
      mat = ei / MAT_ELEMS;
      row = (ei / SIZE) % SIZE;
      col = ei % SIZE;
      return ADDR_WIDTH'(mat * MAT_ELEMS + row + col * SIZE);
   endfunction

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         acc_q        <= '0;
         ndig_q       <= '0;
         elem_count_q <= '0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_data_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         ndig_q       <= ndig_d;
         elem_count_q <= elem_count_d;
         sram_we_q    <= sram_we_d;
         sram_addr_q  <= sram_addr_d;
         sram_data_q  <= sram_data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   // Next-state logic; the write strobe is set on entry to S_WRITE so it is high exactly then.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      ndig_d       = ndig_q;
      elem_count_d = elem_count_q;
      sram_we_d    = 1'b0;
      sram_addr_d  = sram_addr_q;
      sram_data_d  = sram_data_q;
      done_d       = done_q;
      error_d      = error_q;

      if (start) begin
         state_d      = S_RECV;
         acc_d        = '0;
         ndig_d       = '0;
         elem_count_d = '0;
         done_d       = 1'b0;
         error_d      = 1'b0;
      end else begin
         case (state_q)
            S_RECV: begin
               if (rx_valid) begin
                  if (dec.is_digit) begin
                     if (ndig_q == NDW'(MAX_DIGITS)) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                     end else begin
                        acc_d  = {acc_q[DATA_WIDTH-5:0], dec.nibble};
                        ndig_d = ndig_q + NDW'(1);
                     end
                  end else if (dec.is_sep) begin
                     if (ndig_q != '0) begin
                        state_d     = S_WRITE;
                        sram_we_d   = 1'b1;
                        sram_addr_d = col_major_addr(elem_count_q);
                        sram_data_d = acc_q;
                     end
                  end else begin
                     state_d = S_ERR;
                     error_d = 1'b1;
                  end
               end
            end
            S_WRITE: begin
               acc_d        = '0;
               ndig_d       = '0;
               elem_count_d = elem_count_q + CW'(1);
               if (elem_count_q + CW'(1) == CW'(TOTAL)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RECV;
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d == S_RECV) || (state_d == S_WRITE);
   end

   assign sram_we    = sram_we_q;
   assign sram_addr  = sram_addr_q;
   assign sram_data  = sram_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign elem_count = elem_count_q;

`ifdef LOADER_ECHO_EN
   logic       echo_valid_q, echo_valid_d;
   logic [7:0] echo_byte_q, echo_byte_d;

   // Echo registers; tx_busy is sampled with the byte, a busy UART drops the echo.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         echo_valid_q <= 1'b0;
         echo_byte_q  <= '0;
      end else begin
         echo_valid_q <= echo_valid_d;
         echo_byte_q  <= echo_byte_d;
      end
   end

   // Capture every byte accepted while receiving.
   always_comb begin
      echo_valid_d = 1'b0;
      echo_byte_d  = echo_byte_q;
      if (!start && rx_valid && state_q == S_RECV) begin
         echo_byte_d  = rx_byte;
         echo_valid_d = !tx_busy;
      end
   end

   assign echo_valid = echo_valid_q;
   assign echo_byte  = echo_byte_q;
`else
   logic unused_tx_busy;

   assign unused_tx_busy = tx_busy;
   assign echo_valid     = 1'b0;
   assign echo_byte      = 8'h00;
`endif

endmodule

// File: tb/tb_matrix_uart_loader.sv
// Directed self-checking bench for matrix_uart_loader.
module tb_matrix_uart_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        sram_we;
   logic [10:0] sram_addr;
   logic [17:0] sram_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [5:0]  elem_count;
   logic        echo_valid;
   logic [7:0]  echo_byte;
   logic        tx_busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [10:0] wr_addr[$];
   logic [17:0] wr_data[$];
   logic [7:0]  echo_log[$];
   int          we_double = 0;
   logic        we_prev   = 1'b0;

   matrix_uart_loader dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_data  (sram_data),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .elem_count (elem_count),
      .echo_valid (echo_valid),
      .echo_byte  (echo_byte),
      .tx_busy    (tx_busy)
   );

   always #5 clk = ~clk;

   // Log writes and echoes away from the active edge.
   always @(negedge clk) begin
      if (sram_we) begin
         wr_addr.push_back(sram_addr);
         wr_data.push_back(sram_data);
      end
      if (sram_we && we_prev) we_double++;
      we_prev = sram_we;
      if (echo_valid) echo_log.push_back(echo_byte);
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int base;
      reset_n  = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      tx_busy  = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++; if ({sram_we, busy, done, error} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {sram_we, busy, done, error}); else n_pass++;
      n_checks++; if (sram_addr !== 11'd0) $display("FAIL reset_addr: got %0d expected 0", sram_addr); else n_pass++;
      n_checks++; if (sram_data !== 18'd0) $display("FAIL reset_data: got %h expected 0", sram_data); else n_pass++;
      n_checks++; if (elem_count !== 6'd0) $display("FAIL reset_count: got %0d expected 0", elem_count); else n_pass++;
      n_checks++; if ({echo_valid, echo_byte} !== 9'd0) $display("FAIL reset_echo: got %h expected 0", {echo_valid, echo_byte}); else n_pass++;
      // Idle ignores received bytes.
      base = wr_addr.size();
      send_str("5 ");
      n_checks++; if (wr_addr.size() - base !== 0) $display("FAIL idle_ignore: got %0d writes expected 0", wr_addr.size() - base); else n_pass++;
   endtask

   task automatic test_full_load();
      int base, bad, e, exp_addr;
      do_start();
      n_checks++; if (busy !== 1'b1) $display("FAIL start_busy: got %b expected 1", busy); else n_pass++;
      base = wr_addr.size();
      for (int v = 1; v <= 32; v++) begin
         send_str($sformatf("%0X", v));
         if (v < 32) send_byte(8'h20);
      end
      send_str("\r\n");
      n_checks++; if (wr_addr.size() - base !== 32) $display("FAIL full_count_writes: got %0d expected 32", wr_addr.size() - base); else n_pass++;
      if (wr_addr.size() - base == 32) begin
         n_checks++; if (wr_addr[base+1] !== 11'd4) $display("FAIL addr_e1: got %0d expected 4", wr_addr[base+1]); else n_pass++;
         n_checks++; if (wr_addr[base+4] !== 11'd1) $display("FAIL addr_e4: got %0d expected 1", wr_addr[base+4]); else n_pass++;
         n_checks++; if (wr_addr[base+16] !== 11'd16) $display("FAIL addr_e16: got %0d expected 16", wr_addr[base+16]); else n_pass++;
         n_checks++; if (wr_addr[base+7] !== 11'd13) $display("FAIL addr_e7: got %0d expected 13", wr_addr[base+7]); else n_pass++;
         n_checks++; if (wr_data[base+31] !== 18'h20) $display("FAIL data_e31: got %h expected 20", wr_data[base+31]); else n_pass++;
         n_checks++; if (wr_data[base+9] !== 18'hA) $display("FAIL data_e9: got %h expected a", wr_data[base+9]); else n_pass++;
         bad = 0;
         for (int i = 0; i < 32; i++) begin
            e = i;
            exp_addr = (e / 16) * 16 + ((e / 4) % 4) + (e % 4) * 4;
            if (wr_addr[base+i] !== 11'(exp_addr) || wr_data[base+i] !== 18'(i + 1)) bad++;
         end
         n_checks++; if (bad !== 0) $display("FAIL full_layout: got %0d bad entries expected 0", bad); else n_pass++;
      end
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL full_done: got done=%b busy=%b expected 1/0", done, busy); else n_pass++;
      n_checks++; if (elem_count !== 6'd32) $display("FAIL full_elem_count: got %0d expected 32", elem_count); else n_pass++;
      n_checks++; if (we_double !== 0) $display("FAIL we_single_cycle: got %0d multi-cycle strobes expected 0", we_double); else n_pass++;
      base = wr_addr.size();
      send_str("5 ");
      n_checks++; if (wr_addr.size() - base !== 0 || elem_count !== 6'd32) $display("FAIL after_done: got %0d writes count %0d expected 0/32", wr_addr.size() - base, elem_count); else n_pass++;
   endtask

   task automatic test_separators();
      int base;
      do_start();
      n_checks++; if (done !== 1'b0 || elem_count !== 6'd0) $display("FAIL restart_clear: got done=%b count=%0d expected 0/0", done, elem_count); else n_pass++;
      base = wr_addr.size();
      send_str("[ 3FFFF, 0001,ff ]");
      n_checks++; if (wr_addr.size() - base !== 3) $display("FAIL sep_writes: got %0d expected 3", wr_addr.size() - base); else n_pass++;
      if (wr_addr.size() - base == 3) begin
         n_checks++; if ({wr_data[base], wr_data[base+1], wr_data[base+2]} !== {18'h3FFFF, 18'h1, 18'hFF}) $display("FAIL sep_data: got %h %h %h expected 3ffff 1 ff", wr_data[base], wr_data[base+1], wr_data[base+2]); else n_pass++;
         n_checks++; if ({wr_addr[base], wr_addr[base+1], wr_addr[base+2]} !== {11'd0, 11'd4, 11'd8}) $display("FAIL sep_addr: got %0d %0d %0d expected 0 4 8", wr_addr[base], wr_addr[base+1], wr_addr[base+2]); else n_pass++;
      end
      n_checks++; if (elem_count !== 6'd3 || busy !== 1'b1) $display("FAIL sep_count: got %0d busy=%b expected 3/1", elem_count, busy); else n_pass++;
      base = wr_addr.size();
      send_str("ABCDE ");
      n_checks++; if (wr_data.size() - base !== 1 || wr_data[wr_data.size()-1] !== 18'h2BCDE) $display("FAIL truncate: got %h expected 2bcde", wr_data[wr_data.size()-1]); else n_pass++;
   endtask

   task automatic test_overflow();
      int base;
      do_start();
      base = wr_addr.size();
      send_str("12345");
      n_checks++; if (error !== 1'b0) $display("FAIL five_digits_ok: got error=%b expected 0", error); else n_pass++;
      send_str("6");
      n_checks++; if (error !== 1'b1 || busy !== 1'b0) $display("FAIL sixth_digit: got error=%b busy=%b expected 1/0", error, busy); else n_pass++;
      send_str(" ");
      n_checks++; if (wr_addr.size() - base !== 0) $display("FAIL overflow_nowrite: got %0d writes expected 0", wr_addr.size() - base); else n_pass++;
   endtask

   task automatic test_illegal();
      int base;
      do_start();
      n_checks++; if (error !== 1'b0) $display("FAIL start_clears_error: got %b expected 0", error); else n_pass++;
      base = wr_addr.size();
      send_str("12G");
      n_checks++; if (error !== 1'b1) $display("FAIL illegal_char: got error=%b expected 1", error); else n_pass++;
      send_str(" ");
      n_checks++; if (wr_addr.size() - base !== 0) $display("FAIL illegal_nowrite: got %0d writes expected 0", wr_addr.size() - base); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int base;
      do_start();
      send_str("1 2 3 4 5 ");
      n_checks++; if (elem_count !== 6'd5) $display("FAIL mid_count: got %0d expected 5", elem_count); else n_pass++;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++; if (elem_count !== 6'd0 || busy !== 1'b0 || sram_addr !== 11'd0) $display("FAIL mid_reset: got count=%0d busy=%b addr=%0d expected 0/0/0", elem_count, busy, sram_addr); else n_pass++;
      do_start();
      base = wr_addr.size();
      send_str("77 ");
      n_checks++; if (wr_addr.size() - base !== 1 || wr_addr[base] !== 11'd0 || wr_data[base] !== 18'h77) $display("FAIL after_reset_write: got %0d writes addr %0d data %h expected 1/0/77", wr_addr.size() - base, wr_addr[wr_addr.size()-1], wr_data[wr_data.size()-1]); else n_pass++;
   endtask

   task automatic test_restart();
      int base;
      do_start();
      send_str("12");
      do_start();
      base = wr_addr.size();
      send_str("9 ");
      n_checks++; if (wr_addr.size() - base !== 1 || wr_data[base] !== 18'h9 || wr_addr[base] !== 11'd0) $display("FAIL restart_busy: got data %h addr %0d expected 9/0", wr_data[wr_data.size()-1], wr_addr[wr_addr.size()-1]); else n_pass++;
      @(negedge clk);
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_byte  = 8'h37;
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      base = wr_addr.size();
      send_str("8 ");
      n_checks++; if (wr_addr.size() - base !== 1 || wr_data[base] !== 18'h8 || wr_addr[base] !== 11'd0) $display("FAIL start_priority: got data %h addr %0d expected 8/0", wr_data[wr_data.size()-1], wr_addr[wr_addr.size()-1]); else n_pass++;
   endtask

   task automatic test_echo();
`ifdef LOADER_ECHO_EN
      int base;
      tx_busy = 1'b0;
      do_start();
      base = echo_log.size();
      send_str("A,");
      n_checks++; if (echo_log.size() - base !== 2) $display("FAIL echo_count: got %0d expected 2", echo_log.size() - base); else n_pass++;
      if (echo_log.size() - base == 2) begin
         n_checks++; if ({echo_log[base], echo_log[base+1]} !== 16'h412C) $display("FAIL echo_bytes: got %h %h expected 41 2c", echo_log[base], echo_log[base+1]); else n_pass++;
      end
      tx_busy = 1'b1;
      base = echo_log.size();
      send_str("A,");
      n_checks++; if (echo_log.size() - base !== 0) $display("FAIL echo_tx_busy: got %0d expected 0", echo_log.size() - base); else n_pass++;
      tx_busy = 1'b0;
`else
      tx_busy = 1'b1;
      do_start();
      send_str("A,");
      n_checks++; if (echo_log.size() !== 0 || echo_byte !== 8'h00) $display("FAIL echo_disabled: got %0d echoes byte %h expected 0/00", echo_log.size(), echo_byte); else n_pass++;
      tx_busy = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_separators();
      test_overflow();
      test_illegal();
      test_reset_mid();
      test_restart();
      test_echo();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
